// File: rtl/aes_inv_cipher_core.sv
// Iterative AES-128 inverse cipher: expands the forward key up to round key 10, then runs one inverse
// round per cycle while unwinding the key schedule backwards.

package aes_inv_core_pkg;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // a^254 is the multiplicative inverse; 0 maps to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  // Multiply by a 4-bit constant as a sum of the xtime chain a, 2a, 4a, 8a.
  function automatic logic [7:0] gmul_const(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? a : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {
      gmul_const(a0, 4'he) ^ gmul_const(a1, 4'hb) ^ gmul_const(a2, 4'hd) ^ gmul_const(a3, 4'h9),
      gmul_const(a0, 4'h9) ^ gmul_const(a1, 4'he) ^ gmul_const(a2, 4'hb) ^ gmul_const(a3, 4'hd),
      gmul_const(a0, 4'hd) ^ gmul_const(a1, 4'h9) ^ gmul_const(a2, 4'he) ^ gmul_const(a3, 4'hb),
      gmul_const(a0, 4'hb) ^ gmul_const(a1, 4'hd) ^ gmul_const(a2, 4'h9) ^ gmul_const(a3, 4'he)
    };
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);
  import aes_inv_core_pkg::*;
  logic [7:0] inv;
  assign inv   = gf_inv(in_i);
  assign out_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_inv_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);
  import aes_inv_core_pkg::*;
  logic [7:0] pre;
  assign pre   = {in_i[6:0], in_i[7]} ^ {in_i[4:0], in_i[7:5]} ^ {in_i[1:0], in_i[7:2]} ^ 8'h05;
  assign out_o = gf_inv(pre);
endmodule

module aes_inv_cipher_core #(
  parameter bit KEY_REUSE = 1'b1
) (
  input  logic         AES_clk,
  input  logic         AES_rst,
  input  logic         AES_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic         AES_ready,
  output logic         AES_busy,
  output logic [127:0] AES_data_out,
  output logic         AES_data_out_valid
);
  import aes_inv_core_pkg::*;

  typedef enum logic [1:0] {StIdle, StExpand, StRound} state_e;

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] ct_q, ct_d;
  logic [127:0] key_q, key_d;
  logic [127:0] st_q, st_d;
  logic [127:0] out_q, out_d;
  logic [127:0] ckey_q, ckey_d;
  logic [127:0] crk_q, crk_d;
  logic         valid_q, valid_d;
  logic         cvld_q, cvld_d;

  // Key path: the four forward S-boxes serve both the forward and the inverse key step.
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sw_in, sw_rot, sw_out, temp;
  logic [127:0] fwd_key, inv_key;

  assign {w0, w1, w2, w3} = key_q;
  assign sw_in  = (state_q == StRound) ? (w3 ^ w2) : w3;
  assign sw_rot = {sw_in[23:0], sw_in[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_key_sub
    aes_sbox u_sbox (
      .in_i  (sw_rot[8*i +: 8]),
      .out_o (sw_out[8*i +: 8])
    );
  end

  assign temp    = sw_out ^ {rcon(cnt_q), 24'h000000};
  assign fwd_key = {w0 ^ temp, w0 ^ w1 ^ temp, w0 ^ w1 ^ w2 ^ temp, w0 ^ w1 ^ w2 ^ w3 ^ temp};
  assign inv_key = {w0 ^ temp, w1 ^ w0, w2 ^ w1, w3 ^ w2};

  // Data path: InvShiftRows is pure wiring into the inverse S-boxes (byte n = col*4 + row).
  logic [127:0] isub, rnd, imc;

  for (genvar n = 0; n < 16; n++) begin : g_inv_sub
    localparam int unsigned Col = n / 4;
    localparam int unsigned Row = n % 4;
    localparam int unsigned Src = 4 * ((Col + 4 - Row) % 4) + Row;
    aes_inv_sbox u_inv_sbox (
      .in_i  (st_q[127 - 8*Src -: 8]),
      .out_o (isub[127 - 8*n -: 8])
    );
  end

  assign rnd = isub ^ inv_key;
  assign imc = {inv_mix_col(rnd[127:96]), inv_mix_col(rnd[95:64]),
                inv_mix_col(rnd[63:32]), inv_mix_col(rnd[31:0])};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ct_d    = ct_q;
    key_d   = key_q;
    st_d    = st_q;
    out_d   = out_q;
    ckey_d  = ckey_q;
    crk_d   = crk_q;
    cvld_d  = cvld_q;
    valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (AES_en) begin
          ct_d = AES_data_in;
          if (KEY_REUSE && cvld_q && (AES_key_in == ckey_q)) begin
            key_d   = crk_q;
            st_d    = AES_data_in ^ crk_q;
            cnt_d   = 4'd10;
            state_d = StRound;
          end else begin
            key_d   = AES_key_in;
            ckey_d  = AES_key_in;
            cvld_d  = 1'b0;
            cnt_d   = 4'd1;
            state_d = StExpand;
          end
        end
      end
      StExpand: begin
        key_d = fwd_key;
        if (cnt_q == 4'd10) begin
          st_d    = ct_q ^ fwd_key;
          crk_d   = fwd_key;
          cvld_d  = 1'b1;
          state_d = StRound;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StRound: begin
        key_d = inv_key;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          out_d   = rnd;
          valid_d = 1'b1;
          state_d = StIdle;
        end else begin
          st_d = imc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      ct_q    <= '0;
      key_q   <= '0;
      st_q    <= '0;
      out_q   <= '0;
      ckey_q  <= '0;
      crk_q   <= '0;
      cvld_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ct_q    <= ct_d;
      key_q   <= key_d;
      st_q    <= st_d;
      out_q   <= out_d;
      ckey_q  <= ckey_d;
      crk_q   <= crk_d;
      cvld_q  <= cvld_d;
      valid_q <= valid_d;
    end
  end

  assign AES_ready          = (state_q == StIdle);
  assign AES_busy           = (state_q != StIdle);
  assign AES_data_out       = out_q;
  assign AES_data_out_valid = valid_q;

endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// Bench for aes_inv_cipher_core: FIPS vectors, key cache, held enable, mid-run reset and random
// round trips against a table-driven AES model.

module tb_aes_inv_cipher_core;

  localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] RT_KEY  = 128'haa2bdb40bff6a5e8caa9ba3ebc1e2acc;
  localparam logic [127:0] RT_PT   = 128'h0000006b000000000000000000000000;

  logic         clk = 1'b0;
  logic         rst, en1, en0;
  logic [127:0] data_in, key_in;
  logic         rdy1, busy1, valid1, rdy0, busy0, valid0;
  logic [127:0] out1, out0;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb [256];
  logic [7:0] isb[256];

  always #5 clk = ~clk;

  aes_inv_cipher_core #(.KEY_REUSE(1'b1)) u_dut (
    .AES_clk            (clk),
    .AES_rst            (rst),
    .AES_en             (en1),
    .AES_data_in        (data_in),
    .AES_key_in         (key_in),
    .AES_ready          (rdy1),
    .AES_busy           (busy1),
    .AES_data_out       (out1),
    .AES_data_out_valid (valid1)
  );

  aes_inv_cipher_core #(.KEY_REUSE(1'b0)) u_dut_nr (
    .AES_clk            (clk),
    .AES_rst            (rst),
    .AES_en             (en0),
    .AES_data_in        (data_in),
    .AES_key_in         (key_in),
    .AES_ready          (rdy0),
    .AES_busy           (busy0),
    .AES_data_out       (out0),
    .AES_data_out_valid (valid0)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  task automatic build_tables();
    logic [7:0] p = 8'h01;
    logic [7:0] q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      sb[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
  endtask

  function automatic logic [127:0] m_rk(input logic [127:0] key, input int r);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] m_mix(input logic [127:0] t, input bit inv);
    logic [7:0]   k[4];
    logic [7:0]   a[4];
    logic [7:0]   acc;
    logic [127:0] u;
    if (inv) k = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     k = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) a[i] = t[127 - 8*(4*c+i) -: 8];
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc ^= gm(a[j], k[(j - i + 4) % 4]);
        u[127 - 8*(4*c+i) -: 8] = acc;
      end
    end
    return u;
  endfunction

  function automatic logic [127:0] m_encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s, t;
    s = pt ^ m_rk(key, 0);
    for (int r = 1; r <= 10; r++) begin
      for (int n = 0; n < 16; n++)
        t[127 - 8*n -: 8] = sb[s[127 - 8*(4*((n/4 + n%4) % 4) + n%4) -: 8]];
      if (r < 10) t = m_mix(t, 1'b0);
      s = t ^ m_rk(key, r);
    end
    return s;
  endfunction

  function automatic logic [127:0] m_decrypt(input logic [127:0] ct, input logic [127:0] key);
    logic [127:0] s, t;
    s = ct ^ m_rk(key, 10);
    for (int r = 9; r >= 0; r--) begin
      for (int n = 0; n < 16; n++)
        t[127 - 8*n -: 8] = isb[s[127 - 8*(4*((n/4 + 4 - n%4) % 4) + n%4) -: 8]];
      t = t ^ m_rk(key, r);
      s = (r > 0) ? m_mix(t, 1'b1) : t;
    end
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one block to the chosen instance; report edges from acceptance to valid.
  task automatic run_op(input bit nr, input logic [127:0] key, input logic [127:0] ct,
                        input bit probe, input logic [127:0] rk10,
                        output int lat, output logic [127:0] out);
    int guard = 0;
    while (!(nr ? rdy0 : rdy1) && guard < 60) begin
      @(posedge clk); #1;
      guard++;
    end
    data_in = ct;
    key_in  = key;
    if (nr) en0 = 1'b1; else en1 = 1'b1;
    @(posedge clk); #1;
    en0 = 1'b0;
    en1 = 1'b0;
    data_in = rnd128();
    key_in  = rnd128();
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 1) chk("busy_in_flight", {127'd0, nr ? busy0 : busy1}, 128'd1);
      if (probe && i == 10) chk("rk10_probe", u_dut.key_q, rk10);
      if (nr ? valid0 : valid1) begin
        lat = i;
        break;
      end
    end
    out = nr ? out0 : out1;
  endtask

  task automatic held(input bit nr, input int ncyc, input int period, input logic [127:0] key,
                      input logic [127:0] ct, input logic [127:0] pt, input string tag);
    int           pulses[$];
    int           changes = 0;
    int           badout = 0;
    int           d1, d2;
    int           guard = 0;
    logic [127:0] prev;
    logic [127:0] o;
    while (!(nr ? rdy0 : rdy1) && guard < 60) begin
      @(posedge clk); #1;
      guard++;
    end
    data_in = ct;
    key_in  = key;
    if (nr) en0 = 1'b1; else en1 = 1'b1;
    prev = nr ? out0 : out1;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(posedge clk); #1;
      o = nr ? out0 : out1;
      if (nr ? valid0 : valid1) begin
        pulses.push_back(cyc);
        if (o !== pt) badout++;
      end else if (o !== prev) begin
        changes++;
      end
      prev = o;
    end
    en0 = 1'b0;
    en1 = 1'b0;
    d1 = (pulses.size() >= 2) ? pulses[1] - pulses[0] : -1;
    d2 = (pulses.size() >= 3) ? pulses[2] - pulses[1] : -1;
    chk({tag, "_pulses"}, 128'(pulses.size()), 128'd3);
    chk({tag, "_period1"}, 128'(d1), 128'(period));
    chk({tag, "_period2"}, 128'(d2), 128'(period));
    chk({tag, "_out_changes"}, 128'(changes), 128'd0);
    chk({tag, "_bad_out"}, 128'(badout), 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat;
    int           pulses;
    logic [127:0] out, k, pt, ct;

    build_tables();
    rst = 1'b1; en1 = 1'b0; en0 = 1'b0; data_in = '0; key_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {127'd0, rdy1}, 128'd1);
    chk("rst_busy", {127'd0, busy1}, 128'd0);
    chk("rst_valid", {127'd0, valid1}, 128'd0);
    chk("rst_out", out1, 128'd0);
    rst = 1'b0;

    chk("model_c1_decrypt", m_decrypt(C1_CT, C1_KEY), C1_PT);

    // FIPS vectors and key cache on the reusing instance.
    run_op(1'b0, C1_KEY, C1_CT, 1'b1, C1_RK10, lat, out);
    chk("c1_lat", 128'(lat), 128'd20);
    chk("c1_out", out, C1_PT);
    run_op(1'b0, B_KEY, B_CT, 1'b1, B_RK10, lat, out);
    chk("b_lat", 128'(lat), 128'd20);
    chk("b_out", out, B_PT);
    run_op(1'b0, B_KEY, B_CT, 1'b0, '0, lat, out);
    chk("b_hit_lat", 128'(lat), 128'd10);
    chk("b_hit_out", out, B_PT);
    run_op(1'b0, C1_KEY, C1_CT, 1'b1, C1_RK10, lat, out);
    chk("c1_again_lat", 128'(lat), 128'd20);
    chk("c1_again_out", out, C1_PT);

    // Same sequence without key reuse: always a full expansion.
    run_op(1'b1, C1_KEY, C1_CT, 1'b0, '0, lat, out);
    chk("nr_c1_lat", 128'(lat), 128'd20);
    chk("nr_c1_out", out, C1_PT);
    for (int i = 0; i < 2; i++) begin
      run_op(1'b1, B_KEY, B_CT, 1'b0, '0, lat, out);
      chk("nr_b_lat", 128'(lat), 128'd20);
      chk("nr_b_out", out, B_PT);
    end
    run_op(1'b1, C1_KEY, C1_CT, 1'b0, '0, lat, out);
    chk("nr_c1b_lat", 128'(lat), 128'd20);
    chk("nr_c1b_out", out, C1_PT);

    // Round trip against the forward model.
    ct = m_encrypt(RT_PT, RT_KEY);
    run_op(1'b0, RT_KEY, ct, 1'b0, '0, lat, out);
    chk("rt_out", out, RT_PT);

    // Random keys: a full run followed by a cache hit with a fresh plaintext.
    for (int i = 0; i < 6; i++) begin
      k  = rnd128();
      pt = rnd128();
      run_op(1'b0, k, m_encrypt(pt, k), 1'b0, '0, lat, out);
      chk("rand_lat", 128'(lat), 128'd20);
      chk("rand_out", out, pt);
      pt = rnd128();
      run_op(1'b0, k, m_encrypt(pt, k), 1'b0, '0, lat, out);
      chk("rand_hit_lat", 128'(lat), 128'd10);
      chk("rand_hit_out", out, pt);
    end
    k  = rnd128();
    pt = rnd128();
    run_op(1'b1, k, m_encrypt(pt, k), 1'b0, '0, lat, out);
    chk("nr_rand_out", out, pt);

    // Held enable: 21-cycle period without reuse, 11 with a warm cache.
    held(1'b1, 70, 21, C1_KEY, C1_CT, C1_PT, "held_nr");
    run_op(1'b0, B_KEY, B_CT, 1'b0, '0, lat, out);
    held(1'b0, 40, 11, B_KEY, B_CT, B_PT, "held_hit");

    // Reset in ROUND at cnt=5 (10 expand + 5 round edges after acceptance).
    k  = rnd128();
    pt = rnd128();
    while (!rdy1) begin
      @(posedge clk); #1;
    end
    data_in = m_encrypt(pt, k);
    key_in  = k;
    en1     = 1'b1;
    @(posedge clk); #1;
    en1 = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_out", out1, 128'd0);
    chk("mid_rst_ready", {127'd0, rdy1}, 128'd1);
    chk("mid_rst_valid", {127'd0, valid1}, 128'd0);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (valid1) pulses++;
    end
    chk("mid_rst_no_pulse", 128'(pulses), 128'd0);
    run_op(1'b0, k, m_encrypt(pt, k), 1'b0, '0, lat, out);
    chk("post_rst_lat", 128'(lat), 128'd20);
    chk("post_rst_out", out, pt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
